div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 24 ++
 rtl/div_ctrl_if.sv | 24 ++
 rtl/div_step.sv | 26 ++
 rtl/div_ctrl.sv | 138 +++++++++++++
 tb/tb_div_ctrl.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the iterative divider controller.
// State encoding, iteration count and operand magnitude/sign helpers.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } div_state_e;

    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned DIV_CNT_W = 5;

    // Magnitude of a 32-bit operand; 0x80000000 maps onto itself, which is the correct
    // unsigned magnitude.
    function automatic logic [31:0] op_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage divider handshake: operands and control in, stall/ready/result out.
interface div_ctrl_if;

    logic        div_startE;
    logic        div_signedE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        cancelE;
    logic        stall_divE;
    logic        div_readyE;
    logic [31:0] div_hiE;
    logic [31:0] div_loE;

    modport master (
        output div_startE, div_signedE, srcaE, srcbE, cancelE,
        input  stall_divE, div_readyE, div_hiE, div_loE
    );

    modport slave (
        input  div_startE, div_signedE, srcaE, srcbE, cancelE,
        output stall_divE, div_readyE, div_hiE, div_loE
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step of unsigned 32-bit division.
module div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] div_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[31]};
        diff    = shifted - {1'b0, div_i};
        // No borrow means the shifted remainder was at least the divisor.
        if (!diff[32]) begin
            rem_o = diff[31:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller for the execute stage: 32 restoring steps on
// operand magnitudes, sign fix-up in DONE, stall/ready handshake to the hazard unit.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);

    localparam logic [DIV_CNT_W-1:0] CntLast = DIV_CNT_W'(DIV_ITERS - 1);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          rem_q, rem_d;
    logic [31:0]          quo_q, quo_d;
    logic [31:0]          dvs_q, dvs_d;
    logic                 qsign_q, qsign_d;
    logic                 rsign_q, rsign_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;

    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;
    logic        stall;
    logic        ready;

    div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign hi_fix = cond_neg(rem_q, rsign_q);
    assign lo_fix = cond_neg(quo_q, qsign_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;
        ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.div_startE) begin
                    stall = 1'b1;
                    if (!bus.cancelE) begin
                        cnt_d = '0;
                        rem_d = '0;
                        if (bus.srcbE != 32'd0) begin
                            quo_d   = op_mag(bus.srcaE, bus.div_signedE);
                            dvs_d   = op_mag(bus.srcbE, bus.div_signedE);
                            qsign_d = bus.div_signedE & (bus.srcaE[31] ^ bus.srcbE[31]);
                            rsign_d = bus.div_signedE & bus.srcaE[31];
                            state_d = StBusy;
                        end else begin
                            // Divide by zero: skip iteration and report hi=lo=0.
                            quo_d   = '0;
                            dvs_d   = '0;
                            qsign_d = 1'b0;
                            rsign_d = 1'b0;
                            state_d = StDone;
                        end
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ready   = 1'b1;
                hi_d    = hi_fix;
                lo_d    = lo_fix;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A flushed instruction must neither stall nor commit a result.
        if (bus.cancelE) begin
            stall   = 1'b0;
            ready   = 1'b0;
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.stall_divE = stall & ~rst;
    assign bus.div_readyE = ready & ~rst;
    // Result is visible in the DONE cycle so the pipeline can write HI/LO as it advances.
    assign bus.div_hiE    = bus.div_readyE ? hi_fix : hi_q;
    assign bus.div_loE    = bus.div_readyE ? lo_fix : lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, zero divisor,
// cancel, back-to-back operations and reset mid-operation.
module tb_div_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    div_ctrl_if u_if ();

    div_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Starts one divide in the current IDLE cycle, scrambles operands while busy,
    // and checks stall length and the DONE-cycle result.
    task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lo,
                          input logic [31:0] hi, input int stall_exp, input bit back);
        int n = 0;
        u_if.div_startE  = 1'b1;
        u_if.div_signedE = sg;
        u_if.srcaE       = a;
        u_if.srcbE       = b;
        #1;
        while (u_if.stall_divE === 1'b1 && n < 40) begin
            n++;
            tick();
            u_if.srcaE       = $urandom;
            u_if.srcbE       = $urandom;
            u_if.div_signedE = 1'($urandom);
            #1;
        end
        chk({tag, " stall cycles"}, 32'(n), 32'(stall_exp));
        chk({tag, " ready"}, {31'd0, u_if.div_readyE}, 32'd1);
        chk({tag, " lo"}, u_if.div_loE, lo);
        chk({tag, " hi"}, u_if.div_hiE, hi);
        tick();
        if (!back) begin
            u_if.div_startE = 1'b0;
            #1;
            chk({tag, " ready after"}, {31'd0, u_if.div_readyE}, 32'd0);
            chk({tag, " lo hold"}, u_if.div_loE, lo);
            chk({tag, " hi hold"}, u_if.div_hiE, hi);
        end
    endtask

    initial begin
        int seen;
        rst              = 1'b1;
        u_if.div_startE  = 1'b1;
        u_if.div_signedE = 1'b0;
        u_if.srcaE       = 32'd100;
        u_if.srcbE       = 32'd7;
        u_if.cancelE     = 1'b0;
        tick();
        tick();
        chk("reset stall", {31'd0, u_if.stall_divE}, 32'd0);
        chk("reset ready", {31'd0, u_if.div_readyE}, 32'd0);
        chk("reset hi", u_if.div_hiE, 32'd0);
        chk("reset lo", u_if.div_loE, 32'd0);
        rst             = 1'b0;
        u_if.div_startE = 1'b0;
        #1;
        chk("idle stall", {31'd0, u_if.stall_divE}, 32'd0);

        do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);

        // Cancel on the 10th BUSY cycle; prior result (lo=-3, hi=1) must survive.
        u_if.div_startE  = 1'b1;
        u_if.div_signedE = 1'b0;
        u_if.srcaE       = 32'd50;
        u_if.srcbE       = 32'd5;
        #1;
        chk("cancel start stall", {31'd0, u_if.stall_divE}, 32'd1);
        repeat (10) tick();
        u_if.cancelE = 1'b1;
        #1;
        chk("cancel stall", {31'd0, u_if.stall_divE}, 32'd0);
        chk("cancel ready", {31'd0, u_if.div_readyE}, 32'd0);
        tick();
        u_if.cancelE    = 1'b0;
        u_if.div_startE = 1'b0;
        #1;
        chk("post-cancel stall", {31'd0, u_if.stall_divE}, 32'd0);
        chk("post-cancel hi", u_if.div_hiE, 32'd1);
        chk("post-cancel lo", u_if.div_loE, 32'hFFFF_FFFD);
        seen = 0;
        repeat (36) begin
            tick();
            if (u_if.div_readyE !== 1'b0) seen++;
        end
        chk("post-cancel no ready", 32'(seen), 32'd0);
        chk("post-cancel lo hold", u_if.div_loE, 32'hFFFF_FFFD);

        do_div("div 5/0", 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1, 1'b0);
        do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b0);
        do_div("div -8/2", 1'b1, 32'hFFFF_FFF8, 32'd2, 32'hFFFF_FFFC, 32'd0, 33, 1'b0);
        do_div("divu max/16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 33, 1'b1);
        do_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 1'b0);

        // Reset on the 5th BUSY cycle aborts and clears the held result.
        u_if.div_startE  = 1'b1;
        u_if.div_signedE = 1'b0;
        u_if.srcaE       = 32'd1000;
        u_if.srcbE       = 32'd3;
        #1;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("mid-busy rst stall", {31'd0, u_if.stall_divE}, 32'd0);
        chk("mid-busy rst ready", {31'd0, u_if.div_readyE}, 32'd0);
        tick();
        rst             = 1'b0;
        u_if.div_startE = 1'b0;
        #1;
        chk("after rst lo", u_if.div_loE, 32'd0);
        chk("after rst hi", u_if.div_hiE, 32'd0);
        chk("after rst stall", {31'd0, u_if.stall_divE}, 32'd0);
        do_div("divu 8/2", 1'b0, 32'd8, 32'd2, 32'd4, 32'd0, 33, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
